ederah_kernel_rd_burst_issuer: RTL
==================================

Name: ederah_kernel_rd_burst_issuer

Overview:
- AXI4 read-address issuer for the kernel's memory read path.
- Converts one control-level transfer request (base address, length in beats) into a sequence of AR bursts.
- Throttles issue with an outstanding-burst credit counter: incremented on each AR handshake, decremented on each observed R-channel last beat.
- Signals completion once every burst has been issued and every burst has returned its last beat.

Parameters:
- C_ADDR_WIDTH, 64, byte address width of araddr and ctrl_addr.
- C_DATA_WIDTH, 512, AXI data width in bits; sets the byte stride per beat (C_DATA_WIDTH/8).
- C_LENGTH_WIDTH, 32, width of the transfer length in beats.
- C_BURST_LEN, 64, maximum beats per AR burst. Range 1..256; must not cross a 4 KB boundary for aligned bases.
- C_MAX_OUTSTANDING, 16, maximum number of in-flight AR bursts. Minimum 1.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- ctrl_start, in, 1: one-cycle start pulse; sampled only in IDLE.
- ctrl_addr, in, C_ADDR_WIDTH: base byte address, latched on start.
- ctrl_beats, in, C_LENGTH_WIDTH: transfer length in beats, latched on start.
- ctrl_done, out, 1: one-cycle completion pulse.
- busy, out, 1: high in every state except IDLE.
- m_axi_arvalid, out, 1: AR valid.
- m_axi_arready, in, 1: AR ready.
- m_axi_araddr, out, C_ADDR_WIDTH: burst start byte address.
- m_axi_arlen, out, 8: beats minus 1.
- r_last_xfer, in, 1: one cycle per completed burst (rvalid & rready & rlast).
- outstanding, out, $clog2(C_MAX_OUTSTANDING+1): current in-flight burst count.

Behaviour:
- Reset values: ctrl_done=0, busy=0, m_axi_arvalid=0, m_axi_araddr=0, m_axi_arlen=0, outstanding=0; FSM in IDLE.
- Reset mid-transfer: all of the above are forced the cycle after rst is sampled. No completion is reported. In-flight responses are the system's responsibility.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On ctrl_start, latch address and beat count, and compute bursts_total = ceil(beats/C_BURST_LEN).
  - If beats==0, go to DONE; otherwise go to ISSUE.
  - ctrl_start is ignored in every other state.
- ISSUE:
  - arvalid is registered. It is raised when bursts remain unissued AND (outstanding < C_MAX_OUTSTANDING, or a decrement occurs in the same cycle that frees a credit). Registered arvalid is acceptable: the credit check uses the current outstanding count.
  - Start-to-arvalid latency: start sampled at edge T gives arvalid high in cycle T+1 (credits permitting).
  - Once asserted, arvalid, araddr and arlen hold stable until the handshake (arvalid & arready).
  - On handshake: araddr += C_BURST_LEN*C_DATA_WIDTH/8; remaining beats -= burst length.
  - Every burst has arlen = C_BURST_LEN-1 except the final one, which has arlen = (beats mod C_BURST_LEN)-1 when that remainder is nonzero.
  - Back-to-back issue (arvalid held high across consecutive handshakes) is allowed when credits permit.
  - After the final handshake, go to DRAIN with arvalid low.
- DRAIN: when outstanding==0 (including after a same-cycle decrement), go to DONE.
- DONE: ctrl_done=1 for exactly one cycle, then go to IDLE.
- Outstanding counter:
  - +1 on AR handshake; -1 on r_last_xfer.
  - Both in the same cycle: count unchanged.
  - r_last_xfer while outstanding==0: protocol error; the counter stays at 0 and does not wrap.
  - Never exceeds C_MAX_OUTSTANDING.
- Address arithmetic: modulo 2^C_ADDR_WIDTH, with no overflow detection.
- Remaining-beat arithmetic: uses C_LENGTH_WIDTH bits; the last burst length is derived from the remaining count, never from underflow.

Test Plan:
- Single short burst: start with addr=0x1000, beats=10, arready=1. Response: one AR with araddr=0x1000, arlen=9. r_last_xfer 4 cycles later; ctrl_done pulses the cycle after r_last_xfer is sampled; busy drops with it.
- Multi-burst, default parameters: addr=0x0, beats=130. Response: 3 ARs with araddr 0x0, 0x1000, 0x2000 and arlen 63, 63, 1. ctrl_done only after the third r_last_xfer.
- Credit limit, C_MAX_OUTSTANDING=2, beats=256, arready=1, no r_last_xfer: exactly 2 handshakes, then arvalid=0 and outstanding=2. One r_last_xfer pulse gives the third AR within 1 cycle.
- Backpressure: arready held 0 for 5 cycles after arvalid rises. Response: arvalid, araddr and arlen stable for all 5 cycles; exactly one handshake when arready=1.
- Simultaneous events: AR handshake coincides with r_last_xfer while outstanding=1. Response: outstanding stays 1. Also: beats=0 start at edge T gives ctrl_done in cycle T+1 with no AR issued.
- Reset mid-operation: assert rst while outstanding=3 and arvalid=1. Response: next cycle arvalid=0, outstanding=0, busy=0, no ctrl_done. A new start afterwards runs normally from the new ctrl_addr.

Source files
------------

// File: rtl/ederah_kernel_rd_burst_issuer.sv
// ederah_kernel_rd_burst_issuer: splits a beat-count read request into credit-throttled AXI4 AR bursts
module ederah_kernel_rd_burst_issuer #(
  parameter int C_ADDR_WIDTH = 64,
  parameter int C_DATA_WIDTH = 512,
  parameter int C_LENGTH_WIDTH = 32,
  parameter int C_BURST_LEN = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0] ctrl_addr,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_beats,
  output logic ctrl_done,
  output logic busy,
  output logic m_axi_arvalid,
  input  logic m_axi_arready,
  output logic [C_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0] m_axi_arlen,
  input  logic r_last_xfer,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding
);
  localparam int OW = $clog2(C_MAX_OUTSTANDING+1);
  localparam logic [C_LENGTH_WIDTH-1:0] BL = C_LENGTH_WIDTH'(C_BURST_LEN);
  localparam logic [C_ADDR_WIDTH-1:0] STRIDE = C_ADDR_WIDTH'(C_BURST_LEN * (C_DATA_WIDTH / 8));
  localparam logic [OW-1:0] MAX_OUT = OW'(C_MAX_OUTSTANDING);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [C_LENGTH_WIDTH-1:0] rem, rem_n, bursts, bursts_n;
  logic [C_ADDR_WIDTH-1:0] addr_n;
  logic [7:0] len_n;
  logic [OW-1:0] out_n;
  logic arvalid_n, hs, inc, dec;
  function automatic logic [7:0] len_of(input logic [C_LENGTH_WIDTH-1:0] b);
    return 8'((b >= BL ? BL : b) - C_LENGTH_WIDTH'(1));
  endfunction
  assign hs = m_axi_arvalid & m_axi_arready;
  assign busy = state != IDLE;
  assign ctrl_done = state == DONE;
  always_comb begin
    inc = hs & ~r_last_xfer;
    dec = r_last_xfer & ~hs & (outstanding != '0);
    out_n = inc ? outstanding + OW'(1) : dec ? outstanding - OW'(1) : outstanding;
    state_n = state;
    addr_n = m_axi_araddr;
    len_n = m_axi_arlen;
    rem_n = rem;
    bursts_n = bursts;
    arvalid_n = 1'b0;
    if (state == IDLE && ctrl_start) begin
      addr_n = ctrl_addr;
      rem_n = ctrl_beats;
      bursts_n = ctrl_beats / BL + C_LENGTH_WIDTH'(ctrl_beats % BL != '0);
      len_n = ctrl_beats != '0 ? len_of(ctrl_beats) : m_axi_arlen;
      arvalid_n = ctrl_beats != '0 && out_n < MAX_OUT;
      state_n = ctrl_beats == '0 ? DONE : ISSUE;
    end else if (state == ISSUE) begin
      if (hs) begin
        addr_n = m_axi_araddr + STRIDE;
        rem_n = rem - (C_LENGTH_WIDTH'(m_axi_arlen) + C_LENGTH_WIDTH'(1));
        bursts_n = bursts - C_LENGTH_WIDTH'(1);
      end
      // a pending request holds; a new one needs a credit after this cycle's updates
      len_n = bursts_n != '0 ? len_of(rem_n) : m_axi_arlen;
      arvalid_n = (m_axi_arvalid & ~hs) | (bursts_n != '0 && out_n < MAX_OUT);
      state_n = bursts_n == '0 ? DRAIN : ISSUE;
    end else if (state == DRAIN) begin
      state_n = out_n == '0 ? DONE : DRAIN;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
      outstanding <= '0;
      rem <= '0;
      bursts <= '0;
    end else begin
      state <= state_n;
      m_axi_arvalid <= arvalid_n;
      m_axi_araddr <= addr_n;
      m_axi_arlen <= len_n;
      outstanding <= out_n;
      rem <= rem_n;
      bursts <= bursts_n;
    end
  end
endmodule
